// File: rtl/lz77_pkg.sv
// lz77_pkg: token field widths, flag encodings and decoder state encoding shared by the LZ77 codec
package lz77_pkg;
  localparam int literal_token_bits = 9;
  localparam int match_token_bits = 19;
  localparam int offset_bits = 12;
  localparam int length_bits = 6;
  localparam logic flag_literal = 1'b1;
  localparam logic flag_match = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_LIT,
    S_MATCH,
    S_READ,
    S_EMIT,
    S_COMPLETE
  } dec_state_t;
endpackage

// File: rtl/lz77_decompressor_if.sv
// lz77_decompressor_if: serial token bit stream in, decoded byte stream out
//   input_bit/input_valid/input_ready/last_input_passed : token bits, MSB first
//   output_data/output_valid/output_ready                : decoded bytes
//   master = upstream/downstream environment, slave = decoder
interface lz77_decompressor_if;
  logic input_bit;
  logic input_valid;
  logic input_ready;
  logic last_input_passed;
  logic [7:0] output_data;
  logic output_valid;
  logic output_ready;
  modport master (
    output input_bit, input_valid, last_input_passed, output_ready,
    input input_ready, output_data, output_valid
  );
  modport slave (
    input input_bit, input_valid, last_input_passed, output_ready,
    output input_ready, output_data, output_valid
  );
endinterface

// File: rtl/lz77_window_ram.sv
// lz77_window_ram: depth x 8 simple dual-port history RAM, registered read-first read port
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr/o_rdata : read port, data valid the cycle after i_re, held otherwise
module lz77_window_ram #(
  parameter int depth = 4095,
  parameter int addr_bits = 12
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [addr_bits-1:0] i_waddr,
  input  logic [7:0]           i_wdata,
  input  logic                 i_re,
  input  logic [addr_bits-1:0] i_raddr,
  output logic [7:0]           o_rdata
);
  logic [7:0] r_mem [depth];
  logic [7:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/lz77_decompressor.sv
// lz77_decompressor: serial-token LZ77 decoder with a history window mirroring the compressor
//   clk/rst          : clock, asynchronous active-high reset
//   i_start          : begin a decode run (sampled in IDLE)
//   o_busy/o_done    : run in progress / run finished (sticky until reset)
//   o_protocol_error : sticky, illegal match token or misplaced last flag
//   o_bytes_written  : bytes handed downstream
//   io_stream        : token bit input and decoded byte output handshakes
module lz77_decompressor
  import lz77_pkg::*;
#(
  parameter int window_size = 4095,
  parameter int window_address_bits = offset_bits,
  parameter int buffer_address_bits = length_bits,
  parameter int minimum_match_length = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_protocol_error,
  output logic [31:0] o_bytes_written,
  lz77_decompressor_if.slave io_stream
);
  localparam int aw = window_address_bits;
  localparam int lw = buffer_address_bits;
  localparam int pw = aw + 1;
  localparam int sw = aw + lw;
  function automatic logic [pw-1:0] wrap(input logic [pw-1:0] s);
    return s >= pw'(window_size) ? s - pw'(window_size) : s;
  endfunction
  dec_state_t r_state, w_next;
  logic [sw-2:0] r_shift;
  logic [sw-1:0] w_tok;
  logic [4:0] r_cnt;
  logic r_is_match, r_last_rx, r_err, r_from_ram;
  logic [aw-1:0] r_offset, r_base, r_window_ptr, w_off, w_waddr, w_raddr;
  logic [lw-1:0] r_length, r_k, w_len;
  logic [pw-1:0] r_chars, w_span;
  logic [7:0] r_lit, w_ram_q;
  logic [31:0] r_bytes;
  logic w_fire, w_hs, w_lit_end, w_match_end, w_bad_last, w_bad_match, w_more;
  assign io_stream.input_ready = (r_state == S_FLAG || r_state == S_LIT || r_state == S_MATCH) && !r_last_rx;
  assign io_stream.output_valid = r_state == S_EMIT;
  assign io_stream.output_data = r_from_ram ? w_ram_q : r_lit;
  assign o_busy = r_state != S_IDLE && r_state != S_COMPLETE;
  assign o_done = r_state == S_COMPLETE;
  assign o_protocol_error = r_err;
  assign o_bytes_written = r_bytes;
  assign w_fire = io_stream.input_valid && io_stream.input_ready;
  assign w_hs = io_stream.output_valid && io_stream.output_ready;
  assign w_tok = {r_shift, io_stream.input_bit};
  assign w_off = w_tok[sw-1 -: aw];
  assign w_len = w_tok[lw-1:0];
  // 13-bit sum: offset + length can reach 4158 and must not wrap
  assign w_span = pw'(w_off) + pw'(w_len);
  assign w_lit_end = r_state == S_LIT && w_fire && r_cnt == 5'(literal_token_bits - 2);
  assign w_match_end = r_state == S_MATCH && w_fire && r_cnt == 5'(match_token_bits - 2);
  assign w_bad_last = w_fire && io_stream.last_input_passed && !(w_lit_end || w_match_end);
  assign w_bad_match = w_match_end && (w_len < lw'(minimum_match_length) || w_span > r_chars);
  assign w_more = r_is_match && (r_k + lw'(1)) < r_length;
  assign w_waddr = r_chars < pw'(window_size) ? aw'(wrap(pw'(r_window_ptr) + r_chars)) : r_window_ptr;
  // offset + k < charsInWindow for a legal match, so one conditional subtract suffices
  assign w_raddr = aw'(wrap(pw'(r_base) + pw'(r_offset) + pw'(r_k)));
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = i_start ? S_FLAG : S_IDLE;
      S_FLAG: w_next = w_bad_last ? S_COMPLETE : w_fire ? (io_stream.input_bit == flag_literal ? S_LIT : S_MATCH) : S_FLAG;
      S_LIT: w_next = w_bad_last ? S_COMPLETE : w_lit_end ? S_EMIT : S_LIT;
      S_MATCH: w_next = (w_bad_last || w_bad_match) ? S_COMPLETE : w_match_end ? S_READ : S_MATCH;
      S_READ: w_next = S_EMIT;
      S_EMIT: w_next = !w_hs ? S_EMIT : w_more ? S_READ : r_last_rx ? S_COMPLETE : S_FLAG;
      default: w_next = S_COMPLETE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt <= '0;
      r_is_match <= 1'b0;
      r_last_rx <= 1'b0;
      r_err <= 1'b0;
      r_from_ram <= 1'b0;
      r_offset <= '0;
      r_base <= '0;
      r_window_ptr <= '0;
      r_length <= '0;
      r_k <= '0;
      r_chars <= '0;
      r_lit <= '0;
      r_bytes <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_window_ptr <= '0;
        r_chars <= '0;
        r_bytes <= '0;
        r_err <= 1'b0;
        r_last_rx <= 1'b0;
      end
      if (w_fire) begin
        r_shift <= w_tok[sw-2:0];
        r_cnt <= r_state == S_FLAG ? 5'd0 : r_cnt + 5'd1;
        if (io_stream.last_input_passed) r_last_rx <= 1'b1;
      end
      if (r_state == S_FLAG && w_fire) r_is_match <= io_stream.input_bit == flag_match;
      if (w_lit_end) begin
        r_lit <= w_tok[7:0];
        r_from_ram <= 1'b0;
      end
      // reads use the base captured here so in-flight appends cannot shift the source
      if (w_match_end) begin
        r_offset <= w_off;
        r_length <= w_len;
        r_base <= r_window_ptr;
        r_k <= '0;
        r_from_ram <= 1'b1;
      end
      if (w_bad_last || w_bad_match) r_err <= 1'b1;
      if (w_hs) begin
        r_bytes <= r_bytes + 32'd1;
        r_k <= r_k + lw'(1);
        if (r_chars < pw'(window_size)) r_chars <= r_chars + pw'(1);
        else r_window_ptr <= r_window_ptr == aw'(window_size - 1) ? '0 : r_window_ptr + aw'(1);
      end
    end
  end
  lz77_window_ram #(
    .depth(window_size),
    .addr_bits(aw)
  ) u_ram (
    .clk(clk),
    .i_we(w_hs),
    .i_waddr(w_waddr),
    .i_wdata(io_stream.output_data),
    .i_re(r_state == S_READ),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_q)
  );
endmodule

// File: tb/tb_lz77_decompressor.sv
// tb_lz77_decompressor: directed token streams with hand-computed expected bytes
module tb_lz77_decompressor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, perr;
  logic [31:0] nbytes;
  logic tog = 1'b0;
  logic ph = 1'b0;
  logic chk_bp = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int total = 0;
  int bad = 0;
  logic [7:0] got[$];
  logic [7:0] ex[$];
  lz77_decompressor_if bus();
  lz77_decompressor dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .o_busy(busy),
    .o_done(done),
    .o_protocol_error(perr),
    .o_bytes_written(nbytes),
    .io_stream(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) #1 ph = ~ph;
  assign bus.output_ready = tog ? ph : 1'b1;
  task automatic chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (bus.output_valid && bus.output_ready) got.push_back(bus.output_data);
    if (chk_bp) begin
      if (prev_stall) chk("hold", bus.output_data, prev_data);
      if (bus.output_valid) chk("no_in", bus.input_ready, 0);
      prev_stall = bus.output_valid && !bus.output_ready;
      prev_data = bus.output_data;
    end else prev_stall = 1'b0;
  end
  function automatic logic [18:0] lit(input logic [7:0] c);
    return {10'd0, 1'b1, c};
  endfunction
  function automatic logic [18:0] mat(input logic [11:0] o, input logic [5:0] l);
    return {1'b0, o, l};
  endfunction
  task automatic send_tok(input logic [18:0] v, input int n, input logic lst);
    for (int i = n - 1; i >= 0; i--) begin
      int t;
      t = 0;
      bus.input_bit = v[i];
      bus.input_valid = 1'b1;
      bus.last_input_passed = lst && (i == 0);
      @(negedge clk);
      while (!bus.input_ready && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (!bus.input_ready) begin
        chk("in_tmo", bus.input_ready, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.input_valid = 1'b0;
    bus.last_input_passed = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    got.delete();
    ex.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    int t;
    t = 0;
    while (!done && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("done", done, 1);
  endtask
  task automatic check_out(input string tag);
    chk({tag, "_n"}, got.size(), ex.size());
    for (int i = 0; i < ex.size() && i < got.size(); i++) chk(tag, got[i], ex[i]);
  endtask
  initial begin
    int t;
    bus.input_bit = 1'b0;
    bus.input_valid = 1'b0;
    bus.last_input_passed = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_perr", perr, 0);
    chk("rst_irdy", bus.input_ready, 0);
    chk("rst_oval", bus.output_valid, 0);
    chk("rst_odat", bus.output_data, 0);
    chk("rst_nb", nbytes, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    go();
    chk("busy", busy, 1);
    send_tok(lit(8'h41), 9, 1'b0);
    @(negedge clk);
    chk("lit_lat", bus.output_valid, 1);
    send_tok(lit(8'h42), 9, 1'b0);
    send_tok(lit(8'h43), 9, 1'b1);
    wait_done(100);
    ex = '{8'h41, 8'h42, 8'h43};
    check_out("lit");
    chk("lit_nb", nbytes, 3);
    chk("lit_perr", perr, 0);
    chk("lit_busy", busy, 0);
    do_reset();
    go();
    send_tok(lit(8'h61), 9, 1'b0);
    send_tok(lit(8'h62), 9, 1'b0);
    send_tok(lit(8'h63), 9, 1'b0);
    send_tok(mat(12'd0, 6'd3), 19, 1'b1);
    @(negedge clk);
    chk("m_lat0", bus.output_valid, 0);
    @(negedge clk);
    chk("m_lat1", bus.output_valid, 1);
    wait_done(100);
    ex = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
    check_out("match");
    chk("m_nb", nbytes, 6);
    chk("m_perr", perr, 0);
    do_reset();
    tog = 1'b1;
    chk_bp = 1'b1;
    go();
    send_tok(lit(8'h61), 9, 1'b0);
    send_tok(lit(8'h62), 9, 1'b0);
    send_tok(lit(8'h63), 9, 1'b0);
    send_tok(mat(12'd0, 6'd3), 19, 1'b1);
    wait_done(300);
    chk_bp = 1'b0;
    tog = 1'b0;
    ex = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
    check_out("bp");
    chk("bp_nb", nbytes, 6);
    do_reset();
    go();
    send_tok(lit(8'h78), 9, 1'b0);
    send_tok(mat(12'd0, 6'd3), 19, 1'b1);
    wait_done(100);
    repeat (4) @(negedge clk);
    chk("ill_perr", perr, 1);
    chk("ill_nb", nbytes, 1);
    ex = '{8'h78};
    check_out("ill");
    do_reset();
    go();
    for (int i = 0; i < 10; i++) send_tok(lit(8'h10 + 8'(i)), 9, 1'b0);
    send_tok(mat(12'd0, 6'd10), 19, 1'b1);
    t = 0;
    @(negedge clk);
    while (!(bus.output_valid && got.size() >= 13) && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("mc_emit", bus.output_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mc_busy", busy, 0);
    chk("mc_done", done, 0);
    chk("mc_perr", perr, 0);
    chk("mc_irdy", bus.input_ready, 0);
    chk("mc_oval", bus.output_valid, 0);
    chk("mc_odat", bus.output_data, 0);
    chk("mc_nb", nbytes, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
    go();
    send_tok(lit(8'h55), 9, 1'b0);
    send_tok(lit(8'h66), 9, 1'b1);
    wait_done(100);
    ex = '{8'h55, 8'h66};
    check_out("mc_re");
    chk("mc_re_nb", nbytes, 2);
    do_reset();
    go();
    for (int i = 0; i < 4095; i++) begin
      send_tok(lit(8'(i)), 9, 1'b0);
      ex.push_back(8'(i));
    end
    send_tok(mat(12'd4090, 6'd5), 19, 1'b1);
    for (int k = 0; k < 5; k++) ex.push_back(8'(4090 + k));
    wait_done(100);
    chk("wrap_nb", nbytes, 4100);
    chk("wrap_perr", perr, 0);
    check_out("wrap");
    chk("wrap_ptr", dut.r_window_ptr, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
